ucsbece154b_icache: RTL and testbench

- Direct-mapped, read-only instruction cache upstream of the pipelined datapath's fetch stage.
- Looks up the fetch PC (PCF_o) and returns the instruction word that feeds InstrF_i. On a hit the word is returned in the same cycle.
- On a miss it deasserts Ready_o, which the hazard logic turns into StallF/StallD. It then refills one block from main memory using a burst handshake.

---
 rtl/ucsbece154b_icache_if.sv | 38 +++
 rtl/ucsbece154b_icache.sv | 148 ++++++++++++++
 tb/tb_ucsbece154b_icache.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ucsbece154b_icache_if.sv
// ucsbece154b_icache_if
//   Bundles the fetch-side and memory-side signals of the instruction cache.
//   Signal names keep the cache's point of view (_i into the cache, _o out).
//
//   Handshakes:
//     Fetch:  ReadEnable_i/ReadAddress_i are held by the requester until a
//             cycle with Ready_o=1. That cycle returns Instruction_o.
//             Instruction_o is 0 whenever Ready_o=0.
//     Refill: MemReadRequest_o is a one-cycle pulse with MemReadAddress_o
//             block-aligned. Memory then returns the block in order, one
//             word per cycle in which MemDataReady_i=1. There is no
//             back-pressure from the cache.
//   Modports:
//     master - fetch stage and main memory (drives the _i signals)
//     slave  - the cache itself
//   StateDbg_o exposes the cache FSM state for observation.
interface ucsbece154b_icache_if;
    logic        ReadEnable_i;
    logic [31:0] ReadAddress_i;
    logic        Invalidate_i;
    logic [31:0] Instruction_o;
    logic        Ready_o;
    logic [31:0] MemReadAddress_o;
    logic        MemReadRequest_o;
    logic [31:0] MemDataIn_i;
    logic        MemDataReady_i;
    logic [1:0]  StateDbg_o;

    modport master (
        output ReadEnable_i, ReadAddress_i, Invalidate_i, MemDataIn_i, MemDataReady_i,
        input  Instruction_o, Ready_o, MemReadAddress_o, MemReadRequest_o, StateDbg_o
    );

    modport slave (
        input  ReadEnable_i, ReadAddress_i, Invalidate_i, MemDataIn_i, MemDataReady_i,
        output Instruction_o, Ready_o, MemReadAddress_o, MemReadRequest_o, StateDbg_o
    );
endinterface

// File: rtl/ucsbece154b_icache.sv
// ucsbece154b_icache
//   Direct-mapped, read-only instruction cache in front of the fetch stage.
//   A hit returns the word in the same cycle. A miss drops Ready_o, sends a
//   one-cycle burst request, then fills the line from in-order data beats.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   reset  - synchronous, active-low
//   bus    - ucsbece154b_icache_if.slave (fetch lookup + refill burst + state debug)
//   HitCount_o / MissCount_o - saturating performance counters, present only
//            when ICACHE_PERF_COUNTERS_EN is defined
//
// Parameters:
//   NUM_SETS    - number of lines (power of 2, >= 2)
//   BLOCK_WORDS - 32-bit words per line (power of 2, >= 2)
module ucsbece154b_icache #(
    parameter int NUM_SETS    = 8,
    parameter int BLOCK_WORDS = 4
) (
    input  logic clk,
    input  logic reset,
    ucsbece154b_icache_if.slave bus
`ifdef ICACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0] HitCount_o,
    output logic [31:0] MissCount_o
`endif
);
    localparam int OB = $clog2(BLOCK_WORDS);
    localparam int IB = $clog2(NUM_SETS);
    localparam int TB = 32 - OB - IB - 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM_REQ = 2'd1,
        REFILL  = 2'd2
    } state_t;

    state_t stateQ, stateD;

    logic [NUM_SETS-1:0] validQ;
    logic [TB-1:0]       tagMem  [NUM_SETS];
    logic [31:0]         dataMem [NUM_SETS][BLOCK_WORDS];
    logic [OB-1:0]       beatQ;
    logic [31:0]         memAddrQ;

    // Lookup fields come from the live PC; fill fields from the latched miss address.
    logic [OB-1:0] reqOffset;
    logic [IB-1:0] reqIndex;
    logic [TB-1:0] reqTag;
    logic [IB-1:0] fillIndex;
    logic [TB-1:0] fillTag;
    logic          tagMatch;
    logic          lastBeat;
    logic          readyC;
    logic [31:0]   instrC;
    logic          startMiss;
    logic          unusedBits;

    assign reqOffset = bus.ReadAddress_i[OB+1:2];
    assign reqIndex  = bus.ReadAddress_i[OB+IB+1:OB+2];
    assign reqTag    = bus.ReadAddress_i[31:OB+IB+2];
    assign fillIndex = memAddrQ[OB+IB+1:OB+2];
    assign fillTag   = memAddrQ[31:OB+IB+2];
    assign tagMatch  = validQ[reqIndex] && (tagMem[reqIndex] == reqTag);
    assign lastBeat  = bus.MemDataReady_i && (beatQ == OB'(BLOCK_WORDS - 1));

    // Byte-offset bits carry no information for word fetches.
    assign unusedBits = ^{bus.ReadAddress_i[1:0], memAddrQ[OB+1:0]};

    always_comb begin
        stateD    = stateQ;
        readyC    = 1'b0;
        instrC    = '0;
        startMiss = 1'b0;
        case (stateQ)
            IDLE: begin
                // An invalidate owns the cycle: no hit is reported and no
                // miss is started, even if the old tag would still match.
                if (!bus.Invalidate_i && bus.ReadEnable_i) begin
                    if (tagMatch) begin
                        readyC = 1'b1;
                        instrC = dataMem[reqIndex][reqOffset];
                    end else begin
                        startMiss = 1'b1;
                        stateD    = MEM_REQ;
                    end
                end
            end
            MEM_REQ: stateD = REFILL;
            REFILL: begin
                if (lastBeat) stateD = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stateQ   <= IDLE;
            validQ   <= '0;
            beatQ    <= '0;
            memAddrQ <= '0;
        end else begin
            stateQ <= stateD;
            case (stateQ)
                IDLE: begin
                    if (bus.Invalidate_i) validQ <= '0;
                    if (startMiss) memAddrQ <= {bus.ReadAddress_i[31:OB+2], {(OB+2){1'b0}}};
                end
                MEM_REQ: beatQ <= '0;
                REFILL: begin
                    if (bus.MemDataReady_i) begin
                        beatQ <= beatQ + 1'b1;
                        if (lastBeat) validQ[fillIndex] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage has no reset; only the valid bits decide what is usable.
    always_ff @(posedge clk) begin
        if (reset && (stateQ == REFILL) && bus.MemDataReady_i) begin
            dataMem[fillIndex][beatQ] <= bus.MemDataIn_i;
            if (lastBeat) tagMem[fillIndex] <= fillTag;
        end
    end

    assign bus.Ready_o          = readyC;
    assign bus.Instruction_o    = instrC;
    assign bus.MemReadRequest_o = (stateQ == MEM_REQ);
    assign bus.MemReadAddress_o = memAddrQ;
    assign bus.StateDbg_o       = stateQ;

`ifdef ICACHE_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            HitCount_o  <= '0;
            MissCount_o <= '0;
        end else begin
            if (readyC && (HitCount_o != 32'hFFFF_FFFF)) HitCount_o <= HitCount_o + 32'd1;
            if (startMiss && (MissCount_o != 32'hFFFF_FFFF)) MissCount_o <= MissCount_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ucsbece154b_icache.sv
// Bench for ucsbece154b_icache (default NUM_SETS=8, BLOCK_WORDS=4).
// Memory is a 256-word array; the expected cache contents are tracked
// as a valid/block-number pair per set, so a line's data is simply memory.
module tb_ucsbece154b_icache;
    localparam int BW = 4;
    localparam int NS = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ucsbece154b_icache_if bus();
`ifdef ICACHE_PERF_COUNTERS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    ucsbece154b_icache #(.NUM_SETS(NS), .BLOCK_WORDS(BW)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef ICACHE_PERF_COUNTERS_EN
        ,
        .HitCount_o(hit_cnt),
        .MissCount_o(miss_cnt)
`endif
    );

    int total = 0;
    int bad = 0;

    logic [31:0] mem [256];
    bit          model_valid [NS];
    logic [31:0] model_blk [NS];

    logic        s_ready, s_req;
    logic [31:0] s_instr, s_addr;

    bit          resp_active = 0;
    logic [31:0] resp_addr;
    int          resp_beat;
    bit          resp_pat[$];
    bit          next_pat[$];

    typedef struct {
        bit          re;
        logic [31:0] addr;
        bit          inv;
        bit          exp_ready;
        logic [31:0] exp_instr;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem[a[9:2]];
    endfunction

    function automatic int pat_len(input bit q[$]);
        int ones = 0;
        int len = 0;
        bit b;
        while (ones < BW) begin
            b = (len < q.size()) ? q[len] : 1'b1;
            ones += int'(b);
            len++;
        end
        return len;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NS; i++) model_valid[i] = 0;
    endtask

    // One clock: drive the memory responder, sample outputs at the falling
    // edge, then return just after the next rising edge.
    task automatic cycle();
        bit rdy;
        if (resp_active) rdy = (resp_pat.size() > 0) ? resp_pat.pop_front() : 1'b1;
        else rdy = 1'($urandom_range(0, 1));
        bus.MemDataReady_i = rdy;
        bus.MemDataIn_i = (resp_active && rdy) ? mem_rd(resp_addr + 32'(resp_beat * 4)) : $urandom;
        @(negedge clk);
        s_ready = bus.Ready_o;
        s_instr = bus.Instruction_o;
        s_req   = bus.MemReadRequest_o;
        s_addr  = bus.MemReadAddress_o;
        if (resp_active && rdy) begin
            resp_beat++;
            if (resp_beat == BW) resp_active = 0;
        end
        if (s_req === 1'b1) begin
            resp_active = 1;
            resp_addr = s_addr;
            resp_beat = 0;
            resp_pat = next_pat;
            next_pat.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Hold a fetch until Ready_o, comparing against the reference cache.
    task automatic fetch(input string name, input logic [31:0] a);
        int idx, n, req_n, req_cnt, exp_lat, junk;
        bit hit;
        logic [31:0] req_a;
        idx = int'((a >> 4) % NS);
        hit = model_valid[idx] && (model_blk[idx] == (a >> 4));
        exp_lat = hit ? 0 : 2 + pat_len(next_pat);
        bus.ReadEnable_i = 1;
        bus.ReadAddress_i = a;
        bus.Invalidate_i = 0;
        req_n = -1; req_cnt = 0; junk = 0; req_a = '0;
        for (n = 0; n < 40; n++) begin
            cycle();
            if (s_req === 1'b1) begin
                req_cnt++;
                if (req_n < 0) begin req_n = n; req_a = s_addr; end
            end
            if (s_ready === 1'b1) break;
            if (s_instr !== 32'd0) junk++;
        end
        check({name, " latency"}, 32'(n), 32'(exp_lat));
        check({name, " data"}, s_instr, mem_rd(a));
        check({name, " req_count"}, 32'(req_cnt), hit ? 32'd0 : 32'd1);
        if (!hit) begin
            check({name, " req_cycle"}, 32'(req_n), 32'd1);
            check({name, " req_addr"}, req_a, a & ~32'hF);
        end
        check({name, " stall_instr_zero"}, 32'(junk), 32'd0);
        bus.ReadEnable_i = 0;
        model_valid[idx] = 1;
        model_blk[idx] = a >> 4;
        next_pat.delete();
    endtask

    initial begin
        int req_ns[$];
        logic [31:0] req_as[$];
        int n;
        logic [31:0] snap;

        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[4] = 32'h11; mem[5] = 32'h22; mem[6] = 32'h33; mem[7] = 32'h44;
        model_clear();

        vecs[0] = '{1, 32'h14, 0, 1, 32'h22};
        vecs[1] = '{1, 32'h18, 0, 1, 32'h33};
        vecs[2] = '{1, 32'h1F, 0, 1, 32'h44};
        vecs[3] = '{1, 32'h13, 0, 1, 32'h11};
        vecs[4] = '{0, 32'h10, 0, 0, 32'h0};
        vecs[5] = '{1, 32'h10, 1, 0, 32'h0};
        vecs[6] = '{0, 32'h10, 0, 0, 32'h0};

        // Reset state
        reset = 0;
        bus.ReadEnable_i = 0; bus.ReadAddress_i = 0; bus.Invalidate_i = 0;
        bus.MemDataIn_i = 0; bus.MemDataReady_i = 0;
        cycle(); cycle();
        reset = 1;
        cycle();
        check("reset ready", 32'(s_ready), 32'd0);
        check("reset instr", s_instr, 32'd0);
        check("reset req", 32'(s_req), 32'd0);
        check("reset mem_addr", s_addr, 32'd0);

        // Cold miss then hits from the table
        fetch("cold_0x10", 32'h10);
        for (int i = 0; i < 7; i++) begin
            bus.ReadEnable_i = vecs[i].re;
            bus.ReadAddress_i = vecs[i].addr;
            bus.Invalidate_i = vecs[i].inv;
            cycle();
            check($sformatf("vec%0d ready", i), 32'(s_ready), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d instr", i), s_instr, vecs[i].exp_instr);
            check($sformatf("vec%0d req", i), 32'(s_req), 32'd0);
            if (vecs[i].inv) model_clear();
        end
        bus.Invalidate_i = 0;

`ifdef ICACHE_PERF_COUNTERS_EN
        snap = miss_cnt;
`else
        snap = 0;
`endif
        // After invalidate the line misses; then a conflict pair
        fetch("post_inv_0x10", 32'h10);
        fetch("conflict_0x90", 32'h90);
        fetch("conflict_0x10", 32'h10);
`ifdef ICACHE_PERF_COUNTERS_EN
        check("miss_count delta", miss_cnt - snap, 32'd3);
`endif

        // Wait states 1,0,0,1,1,0,1
        next_pat = '{1, 0, 0, 1, 1, 0, 1};
        fetch("wait_0x20", 32'h20);
        fetch("wait_hit_0x24", 32'h24);
        fetch("wait_hit_0x28", 32'h28);
        fetch("wait_hit_0x2C", 32'h2C);

        // Reset after two refill beats
        bus.ReadEnable_i = 1;
        bus.ReadAddress_i = 32'h30;
        for (int i = 0; i < 4; i++) cycle();
        reset = 0;
        cycle();
        reset = 1;
        model_clear();
        fetch("after_reset_0x30", 32'h30);
        fetch("after_reset_0x10", 32'h10);

        // Redirect while 0x50 is filling: fill completes, then 0x40 misses
        bus.ReadEnable_i = 1;
        bus.ReadAddress_i = 32'h50;
        for (n = 0; n < 30; n++) begin
            if (n == 3) bus.ReadAddress_i = 32'h40;
            cycle();
            if (s_req === 1'b1) begin req_ns.push_back(n); req_as.push_back(s_addr); end
            if (s_ready === 1'b1) break;
        end
        check("redirect req_count", 32'(req_ns.size()), 32'd2);
        check("redirect first req cycle", (req_ns.size() > 0) ? 32'(req_ns[0]) : 32'hFFFF_FFFF, 32'd1);
        check("redirect first req addr", (req_as.size() > 0) ? req_as[0] : 32'hFFFF_FFFF, 32'h50);
        check("redirect second req cycle", (req_ns.size() > 1) ? 32'(req_ns[1]) : 32'hFFFF_FFFF, 32'd7);
        check("redirect second req addr", (req_as.size() > 1) ? req_as[1] : 32'hFFFF_FFFF, 32'h40);
        check("redirect ready cycle", 32'(n), 32'd12);
        check("redirect data", s_instr, mem_rd(32'h40));
        bus.ReadEnable_i = 0;
        model_valid[5] = 1; model_blk[5] = 32'h5;
        model_valid[4] = 1; model_blk[4] = 32'h4;
        fetch("redirect_hit_0x50", 32'h50);

        // Randomized traffic against the reference cache
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 9))
                0: begin
                    bus.ReadEnable_i = 0;
                    bus.ReadAddress_i = 32'($urandom_range(0, 1023));
                    cycle();
                    check("rand idle ready", 32'(s_ready), 32'd0);
                    check("rand idle instr", s_instr, 32'd0);
                end
                1: begin
                    bus.ReadEnable_i = 1'($urandom_range(0, 1));
                    bus.ReadAddress_i = 32'($urandom_range(0, 1023));
                    bus.Invalidate_i = 1;
                    cycle();
                    check("rand inv ready", 32'(s_ready), 32'd0);
                    bus.Invalidate_i = 0;
                    bus.ReadEnable_i = 0;
                    cycle();
                    check("rand inv no_req", 32'(s_req), 32'd0);
                    model_clear();
                end
                default: begin
                    next_pat.delete();
                    repeat (BW) begin
                        repeat ($urandom_range(0, 2)) next_pat.push_back(1'b0);
                        next_pat.push_back(1'b1);
                    end
                    fetch($sformatf("rand%0d", k), 32'($urandom_range(0, 1023)));
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
